// File: rtl/pong_uart_frame_tx.sv
// ---------------------------------------------------------------------------
// pong_uart_frame_tx
//
// Transmit back end for inter-board Pong traffic. Accepts one typed game
// message (ball / miss / new-game / new-game-ack) through a ready/request
// handshake. It packs the message into a fixed frame of bytes and sends
// each byte as UART 8N1, LSB first, on UART_TXD. A new byte only starts
// while clear_to_send is high. A byte that has started always finishes.
//
// Compile-time option:
//   FRAME_CHECKSUM_EN  when defined, a fifth byte is appended to the frame.
//                      This byte is the XOR of B0..B3. When undefined,
//                      frames are 4 bytes and there is no checksum logic.
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz
//   BAUD     line rate. CLKS_PER_BIT = CLK_HZ/BAUD and must be >= 2.
//
// Ports:
//   CLOCK_50                 system clock
//   reset                    asynchronous, active-high reset
//   send_new_message         request; sampled only while ready=1
//   ready                    idle and able to accept a request
//   message_sent             one-cycle pulse at the end of a frame
//   ball_message_tx .. new_game_ack_message_tx
//                            message type select (ack > new_game > miss > ball)
//   ball_y_tx, velocity_x_tx, velocity_y_tx, sign_y_tx,
//   my_score_tx, your_score_tx, you_should_serve_tx, you_serve_first_tx
//                            message fields, latched when a request is accepted
//   clear_to_send            peer may accept data (already synchronized)
//   UART_TXD                 serial line; idles high
// ---------------------------------------------------------------------------
module pong_uart_frame_tx #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       send_new_message,
    output logic       ready,
    output logic       message_sent,
    input  logic       ball_message_tx,
    input  logic       miss_message_tx,
    input  logic       new_game_message_tx,
    input  logic       new_game_ack_message_tx,
    input  logic [8:0] ball_y_tx,
    input  logic [3:0] velocity_x_tx,
    input  logic [3:0] velocity_y_tx,
    input  logic       sign_y_tx,
    input  logic [4:0] my_score_tx,
    input  logic [4:0] your_score_tx,
    input  logic       you_should_serve_tx,
    input  logic       you_serve_first_tx,
    input  logic       clear_to_send,
    output logic       UART_TXD
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
`ifdef FRAME_CHECKSUM_EN
    localparam int NUM_BYTES = 5;
`else
    localparam int NUM_BYTES = 4;
`endif
    // The counter must be able to reach CLKS_PER_BIT itself. This is needed
    // for the settle cycle after the last stop bit.
    localparam int CNT_W  = $clog2(CLKS_PER_BIT + 1);
    localparam int BYTE_W = $clog2(NUM_BYTES);

    localparam logic [CNT_W-1:0]  BIT_LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  SETTLE_CNT   = CNT_W'(CLKS_PER_BIT);
    localparam logic [BYTE_W-1:0] LAST_BYTE    = BYTE_W'(NUM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_CTS,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_baud_cnt;
    logic [2:0]          r_bit_idx;
    logic [BYTE_W-1:0]   r_byte_idx;
    logic [7:0]          r_frame [NUM_BYTES];

    state_t              w_state_eff;
    state_t              w_state_next;
    logic [CNT_W-1:0]    w_baud_cnt_next;
    logic [2:0]          w_bit_idx_next;
    logic [BYTE_W-1:0]   w_byte_idx_next;
    logic                w_ready;
    logic                w_any_type;
    logic                w_accept;
    logic [3:0]          w_code;
    logic [7:0]          w_b1;
    logic [7:0]          w_b2;
    logic [7:0]          w_b3;
    logic [7:0]          w_frame [NUM_BYTES];

    assign w_ready    = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_any_type = ball_message_tx | miss_message_tx |
                        new_game_message_tx | new_game_ack_message_tx;
    assign w_accept   = w_ready && send_new_message && w_any_type;
    assign ready      = w_ready;

    // Frame assembly from the live inputs. The result is only captured on
    // the accept edge.
    always_comb begin
        w_code = 4'd0;
        w_b1   = 8'h00;
        w_b2   = 8'h00;
        w_b3   = 8'h00;
        if (new_game_ack_message_tx) begin
            w_code = 4'd4;
        end else if (new_game_message_tx) begin
            w_code = 4'd3;
            w_b1   = {7'b0, you_serve_first_tx};
        end else if (miss_message_tx) begin
            w_code = 4'd2;
            w_b1   = {3'b0, my_score_tx};
            w_b2   = {3'b0, your_score_tx};
            w_b3   = {7'b0, you_should_serve_tx};
        end else if (ball_message_tx) begin
            w_code = 4'd1;
            w_b1   = ball_y_tx[7:0];
            w_b2   = {6'b0, sign_y_tx, ball_y_tx[8]};
            w_b3   = {velocity_x_tx, velocity_y_tx};
        end
    end

    always_comb begin
        w_frame[0] = {4'hA, w_code};
        w_frame[1] = w_b1;
        w_frame[2] = w_b2;
        w_frame[3] = w_b3;
`ifdef FRAME_CHECKSUM_EN
        w_frame[4] = {4'hA, w_code} ^ w_b1 ^ w_b2 ^ w_b3;
`endif
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_BYTES; i++) r_frame[i] <= 8'h00;
        end else if (w_accept) begin
            for (int i = 0; i < NUM_BYTES; i++) r_frame[i] <= w_frame[i];
        end
    end

    // State register and counters
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_cnt_next;
            r_bit_idx  <= w_bit_idx_next;
            r_byte_idx <= w_byte_idx_next;
        end
    end

    // WAIT_CTS with CTS already high behaves as the first cycle of START.
    // Waiting therefore costs no cycles, and the start bit appears in the
    // same cycle that CTS is seen.
    assign w_state_eff = (r_state == S_WAIT_CTS && clear_to_send) ? S_START : r_state;

    // Next-state and outputs
    always_comb begin
        w_state_next    = r_state;
        w_baud_cnt_next = r_baud_cnt;
        w_bit_idx_next  = r_bit_idx;
        w_byte_idx_next = r_byte_idx;
        UART_TXD        = 1'b1;
        message_sent    = 1'b0;

        case (w_state_eff)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_next    = S_WAIT_CTS;
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = '0;
                    w_byte_idx_next = '0;
                end
            end
            S_WAIT_CTS: begin
                w_state_next = S_WAIT_CTS;
            end
            S_START: begin
                UART_TXD = 1'b0;
                if (r_baud_cnt == BIT_LAST_CNT) begin
                    w_state_next    = S_DATA;
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = '0;
                end else begin
                    w_state_next    = S_START;
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                UART_TXD = r_frame[r_byte_idx][r_bit_idx];
                if (r_baud_cnt == BIT_LAST_CNT) begin
                    w_baud_cnt_next = '0;
                    if (r_bit_idx == 3'd7) begin
                        w_state_next = S_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end
            S_STOP: begin
                if (r_byte_idx == LAST_BYTE) begin
                    // The last stop bit gets one more idle-high cycle before
                    // DONE. This places message_sent one cycle after the
                    // final bit period ends.
                    if (r_baud_cnt == SETTLE_CNT) begin
                        w_state_next    = S_DONE;
                        w_baud_cnt_next = '0;
                    end else begin
                        w_baud_cnt_next = r_baud_cnt + 1'b1;
                    end
                end else if (r_baud_cnt == BIT_LAST_CNT) begin
                    w_state_next    = S_WAIT_CTS;
                    w_baud_cnt_next = '0;
                    w_byte_idx_next = r_byte_idx + 1'b1;
                end else begin
                    w_baud_cnt_next = r_baud_cnt + 1'b1;
                end
            end
            S_DONE: begin
                message_sent = 1'b1;
                w_state_next = S_IDLE;
                // A request arriving together with the pulse starts the
                // next frame immediately.
                if (w_accept) begin
                    w_state_next    = S_WAIT_CTS;
                    w_baud_cnt_next = '0;
                    w_bit_idx_next  = '0;
                    w_byte_idx_next = '0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pong_uart_frame_tx.sv
module tb_pong_uart_frame_tx;

    localparam int CLK_HZ = 1000000;
    localparam int BAUD   = 100000;
`ifdef FRAME_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk;
    logic       reset;
    logic       send_new_message;
    logic       ready;
    logic       message_sent;
    logic       ball_message_tx;
    logic       miss_message_tx;
    logic       new_game_message_tx;
    logic       new_game_ack_message_tx;
    logic [8:0] ball_y_tx;
    logic [3:0] velocity_x_tx;
    logic [3:0] velocity_y_tx;
    logic       sign_y_tx;
    logic [4:0] my_score_tx;
    logic [4:0] your_score_tx;
    logic       you_should_serve_tx;
    logic       you_serve_first_tx;
    logic       clear_to_send;
    logic       UART_TXD;

    pong_uart_frame_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .CLOCK_50               (clk),
        .reset                  (reset),
        .send_new_message       (send_new_message),
        .ready                  (ready),
        .message_sent           (message_sent),
        .ball_message_tx        (ball_message_tx),
        .miss_message_tx        (miss_message_tx),
        .new_game_message_tx    (new_game_message_tx),
        .new_game_ack_message_tx(new_game_ack_message_tx),
        .ball_y_tx              (ball_y_tx),
        .velocity_x_tx          (velocity_x_tx),
        .velocity_y_tx          (velocity_y_tx),
        .sign_y_tx              (sign_y_tx),
        .my_score_tx            (my_score_tx),
        .your_score_tx          (your_score_tx),
        .you_should_serve_tx    (you_should_serve_tx),
        .you_serve_first_tx     (you_serve_first_tx),
        .clear_to_send          (clear_to_send),
        .UART_TXD               (UART_TXD)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         n_pass   = 0;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         bad_ctl  = 0;
    logic [7:0] exp_b [5];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_exp(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        exp_b[0] = b0;
        exp_b[1] = b1;
        exp_b[2] = b2;
        exp_b[3] = b3;
        exp_b[4] = b0 ^ b1 ^ b2 ^ b3;
    endtask

    task automatic clear_fields();
        ball_message_tx         = 1'b0;
        miss_message_tx         = 1'b0;
        new_game_message_tx     = 1'b0;
        new_game_ack_message_tx = 1'b0;
        ball_y_tx               = '0;
        velocity_x_tx           = '0;
        velocity_y_tx           = '0;
        sign_y_tx               = 1'b0;
        my_score_tx             = '0;
        your_score_tx           = '0;
        you_should_serve_tx     = 1'b0;
        you_serve_first_tx      = 1'b0;
    endtask

    // Called at the negedge just after fields are set. The bench is then at
    // the first cycle of the B0 start bit.
    task automatic start_frame();
        send_new_message = 1'b1;
        @(negedge clk);
        send_new_message = 1'b0;
    endtask

    // Starts in the first cycle of byte k's start bit. Returns in the first
    // cycle after its stop bit. Every bit must hold for exactly 10 cycles.
    task automatic rx_byte(input int k, input int drop_bit, input string tag);
        logic [9:0] bits;
        logic       first;
        int         unstable;
        unstable = 0;
        for (int b = 0; b < 10; b++) begin
            if (b == drop_bit) clear_to_send = 1'b0;
            first   = UART_TXD;
            bits[b] = first;
            for (int c = 0; c < 10; c++) begin
                if (UART_TXD !== first) unstable++;
                if (ready !== 1'b0 || message_sent !== 1'b0) bad_ctl++;
                @(negedge clk);
            end
        end
        check($sformatf("%s B%0d start", tag, k), 32'(bits[0]), 32'd0);
        check($sformatf("%s B%0d data", tag, k), 32'(bits[8:1]), 32'(exp_b[k]));
        check($sformatf("%s B%0d stop", tag, k), 32'(bits[9]), 32'd1);
        check($sformatf("%s B%0d bit_width", tag, k), unstable, 0);
    endtask

    task automatic finish_frame(input string tag);
        int cyc;
        cyc = 0;
        check({tag, " ctl_in_frame"}, bad_ctl, 0);
        bad_ctl = 0;
        while (message_sent !== 1'b1 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, " sent_latency"}, cyc, 1);
        check({tag, " ready_at_done"}, 32'(ready), 32'd1);
    endtask

    task automatic rx_frame(input string tag);
        for (int k = 0; k < NB; k++) rx_byte(k, -1, tag);
        finish_frame(tag);
    endtask

    task automatic after_pulse(input string tag);
        @(negedge clk);
        check({tag, " pulse_width"}, 32'(message_sent), 32'd0);
        check({tag, " ready_idle"}, 32'(ready), 32'd1);
    endtask

    initial begin
        int cnt;
        reset            = 1'b1;
        send_new_message = 1'b0;
        clear_to_send    = 1'b1;
        clear_fields();
        repeat (3) @(negedge clk);
        check("reset txd", 32'(UART_TXD), 32'd1);
        check("reset ready", 32'(ready), 32'd1);
        check("reset sent", 32'(message_sent), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Ball message. Fields are scrambled right after accept.
        clear_fields();
        ball_message_tx = 1'b1;
        ball_y_tx       = 9'h12C;
        velocity_x_tx   = 4'd3;
        velocity_y_tx   = 4'd2;
        sign_y_tx       = 1'b1;
        set_exp(8'hA1, 8'h2C, 8'h03, 8'h32);
        start_frame();
        ball_y_tx       = 9'h1FF;
        velocity_x_tx   = 4'hF;
        miss_message_tx = 1'b1;
        rx_frame("ball");
        after_pulse("ball");

        // Miss message. The ack+miss request is raised before the pulse,
        // so it must be taken in the DONE cycle.
        clear_fields();
        miss_message_tx     = 1'b1;
        my_score_tx         = 5'd5;
        your_score_tx       = 5'd17;
        you_should_serve_tx = 1'b1;
        set_exp(8'hA2, 8'h05, 8'h11, 8'h01);
        start_frame();
        for (int k = 0; k < NB; k++) rx_byte(k, -1, "miss");
        new_game_ack_message_tx = 1'b1;
        my_score_tx             = 5'd31;
        your_score_tx           = 5'd9;
        send_new_message        = 1'b1;
        finish_frame("miss");
        @(negedge clk);
        send_new_message = 1'b0;
        check("b2b accepted", 32'(ready), 32'd0);
        set_exp(8'hA4, 8'h00, 8'h00, 8'h00);
        rx_frame("ack_prio");
        after_pulse("ack_prio");

        // A request with no type bit set is ignored.
        clear_fields();
        ball_y_tx        = 9'h0F0;
        my_score_tx      = 5'd3;
        send_new_message = 1'b1;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            if (UART_TXD !== 1'b1 || ready !== 1'b1 || message_sent !== 1'b0) cnt++;
            @(negedge clk);
        end
        send_new_message = 1'b0;
        check("no_type ignored", cnt, 0);

        // CTS is dropped during B1 data bits and returns after a gap.
        clear_fields();
        ball_message_tx = 1'b1;
        ball_y_tx       = 9'h0A5;
        velocity_x_tx   = 4'd7;
        velocity_y_tx   = 4'd9;
        set_exp(8'hA1, 8'hA5, 8'h00, 8'h79);
        start_frame();
        rx_byte(0, -1, "cts");
        rx_byte(1, 4, "cts");
        cnt = 0;
        for (int c = 0; c < 25; c++) begin
            if (UART_TXD !== 1'b1) cnt++;
            @(negedge clk);
        end
        check("cts hold_high", cnt, 0);
        clear_to_send = 1'b1;
        #1;
        check("cts start_same_cycle", 32'(UART_TXD), 32'd0);
        for (int k = 2; k < NB; k++) rx_byte(k, -1, "cts");
        finish_frame("cts");
        after_pulse("cts");

        // Reset while a zero data bit of B2 is on the line.
        clear_fields();
        miss_message_tx     = 1'b1;
        my_score_tx         = 5'd5;
        your_score_tx       = 5'd17;
        you_should_serve_tx = 1'b1;
        set_exp(8'hA2, 8'h05, 8'h11, 8'h01);
        start_frame();
        rx_byte(0, -1, "rst");
        rx_byte(1, -1, "rst");
        check("rst ctl_in_frame", bad_ctl, 0);
        bad_ctl = 0;
        repeat (25) @(negedge clk);
        check("rst pre_txd", 32'(UART_TXD), 32'd0);
        reset = 1'b1;
        #1;
        check("rst async_txd", 32'(UART_TXD), 32'd1);
        check("rst async_ready", 32'(ready), 32'd1);
        check("rst async_sent", 32'(message_sent), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 500; c++) begin
            if (message_sent !== 1'b0 || UART_TXD !== 1'b1 || ready !== 1'b1) cnt++;
            @(negedge clk);
        end
        check("rst abandoned", cnt, 0);

        // Full new-game frame after the reset.
        clear_fields();
        new_game_message_tx = 1'b1;
        you_serve_first_tx  = 1'b1;
        set_exp(8'hA3, 8'h01, 8'h00, 8'h00);
        start_frame();
        rx_frame("new_game");
        after_pulse("new_game");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
